xor_cascade_pipe: RTL and testbench



---
 rtl/xor_cascade_pipe_if.sv | 43 ++++
 rtl/xor_cascade_pipe.sv | 100 ++++++++++
 tb/tb_xor_cascade_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/xor_cascade_pipe_if.sv
// xor_cascade_pipe_if
//   Groups the streaming handshake, data, key and observation signals of
//   xor_cascade_pipe.
//   master : the harness side. It drives the input word and keys and
//            out_ready. It observes the results, taps, accumulator and count.
//   slave  : the pipeline side (the DUT).
//   Signals:
//     in_valid/in_ready    input-side handshake
//     in_data  [WIDTH]     operand x
//     in_key   [STAGES*W]  per-cell keys, slice i feeds cell i
//     in_acc               word folds into the running accumulator
//     out_valid/out_ready  output-side handshake
//     out_data [WIDTH]     result
//     stage_tap            registered data of every stage
//     acc_value            current accumulator
//     out_count [CNT_W]    completed output transfers
interface xor_cascade_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [STAGES*WIDTH-1:0]   in_key;
  logic                      in_acc;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [STAGES*WIDTH-1:0]   stage_tap;
  logic [WIDTH-1:0]          acc_value;
  logic [CNT_W-1:0]          out_count;

  modport master (
    output in_valid, in_data, in_key, in_acc, out_ready,
    input  in_ready, out_valid, out_data, stage_tap, acc_value, out_count
  );

  modport slave (
    input  in_valid, in_data, in_key, in_acc, out_ready,
    output in_ready, out_valid, out_data, stage_tap, acc_value, out_count
  );
endinterface

// File: rtl/xor_cascade_pipe.sv
// xor_cascade_pipe
//   Passes an input word through STAGES cascaded XOR cells. Each cell has
//   one register stage and its own key. All stages advance together under
//   valid/ready flow control. A stall at the output freezes the whole pipe,
//   and bubbles are not collapsed.
//   Keys and the accumulate flag travel down the pipe with their word, so
//   in_key may change freely once a word has been accepted.
//   In accumulate mode the result is XORed with the running accumulator.
//   Every output transfer reloads the accumulator with the presented result.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears all state
//     bus    xor_cascade_pipe_if.slave; handshake, data, keys, taps, counter
module xor_cascade_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  xor_cascade_pipe_if.slave bus
);

  localparam int LAST = STAGES - 1;

  // Per-stage pipeline state
  logic             r_vld_p  [STAGES];
  logic [WIDTH-1:0] r_data_p [STAGES];
  logic             r_acc_p  [STAGES];
  // r_key_p[s][j] is key j carried alongside the word held in stage s.
  logic [WIDTH-1:0] r_key_p  [STAGES][STAGES];

  logic [WIDTH-1:0] r_acc_reg;
  logic [CNT_W-1:0] r_out_count;

  logic [WIDTH-1:0] w_key_in [STAGES];
  logic             w_adv;
  logic             w_xfer;
  logic [WIDTH-1:0] w_out_data;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    assign w_key_in[g]                       = bus.in_key[g*WIDTH +: WIDTH];
    assign bus.stage_tap[g*WIDTH +: WIDTH]   = r_data_p[g];
  end

  // The pipe moves only when the last stage is empty or being drained.
  assign w_adv      = !r_vld_p[LAST] || bus.out_ready;
  assign w_xfer     = r_vld_p[LAST] && bus.out_ready;
  assign w_out_data = r_data_p[LAST] ^ (r_acc_p[LAST] ? r_acc_reg : '0);

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_p[LAST];
  assign bus.out_data  = w_out_data;
  assign bus.acc_value = r_acc_reg;
  assign bus.out_count = r_out_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld_p[s]  <= 1'b0;
        r_data_p[s] <= '0;
        r_acc_p[s]  <= 1'b0;
        for (int j = 0; j < STAGES; j++) begin
          r_key_p[s][j] <= '0;
        end
      end
    end else if (w_adv) begin
      // Stage 0: first XOR cell, capture the keys and flag for this word
      r_vld_p[0]  <= bus.in_valid;
      r_data_p[0] <= bus.in_data ^ w_key_in[0];
      r_acc_p[0]  <= bus.in_acc;
      for (int j = 0; j < STAGES; j++) begin
        r_key_p[0][j] <= w_key_in[j];
      end
      // Stages 1..LAST: each cell uses the key carried with its own word
      for (int s = 1; s < STAGES; s++) begin
        r_vld_p[s]  <= r_vld_p[s-1];
        r_data_p[s] <= r_data_p[s-1] ^ r_key_p[s-1][s];
        r_acc_p[s]  <= r_acc_p[s-1];
        for (int j = 0; j < STAGES; j++) begin
          r_key_p[s][j] <= r_key_p[s-1][j];
        end
      end
    end
  end

  // Output stage: the accumulator and the counter change only on a real
  // transfer. A result sent without accumulate reloads the accumulator,
  // which restarts the running parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_reg   <= '0;
      r_out_count <= '0;
    end else if (w_xfer) begin
      r_acc_reg   <= w_out_data;
      r_out_count <= r_out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xor_cascade_pipe.sv
module tb_xor_cascade_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_cascade_pipe_if #(.WIDTH(8), .STAGES(3), .CNT_W(4)) bus ();

  xor_cascade_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word on every output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h expected none at %0t", bus.out_data, $time);
      end else begin
        chk("out_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [23:0] k, input logic a, input logic [7:0] e);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_key   = k;
    bus.in_acc   = a;
    exp_q.push_back(e);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      g++;
      if (g > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic       x_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       y_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] e_t [4] = '{8'h00, 8'h01, 8'h01, 8'h00};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_data",  {24'h0, bus.out_data}, 32'h0);
    chk("rst_stage_tap", {8'h0, bus.stage_tap}, 32'h0);
    chk("rst_acc_value", {24'h0, bus.acc_value}, 32'h0);
    chk("rst_out_count", {28'h0, bus.out_count}, 32'h0);
    chk("rst_in_ready",  {31'h0, bus.in_ready}, 32'h1);

    // Legacy two-cell equivalence: cells 0 and 1 key y, cell 2 transparent
    for (int i = 0; i < 4; i++)
      send({7'h0, x_t[i]}, {8'h00, 7'h0, y_t[i], 7'h0, y_t[i]}, 1'b0, e_t[i]);
    wait_drain();
    chk("legacy_count", {28'h0, bus.out_count}, 32'h4);

    // Distinct keys, stage by stage
    do_reset();
    send(8'hA5, {8'h3C, 8'hF0, 8'h0F}, 1'b0, 8'h66);
    bus.in_key = 24'hFFFFFF;
    chk("tap0", {24'h0, bus.stage_tap[7:0]}, 32'hAA);
    @(posedge clk); #1;
    chk("tap1", {24'h0, bus.stage_tap[15:8]}, 32'h5A);
    chk("not_yet_valid", {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("tap2", {24'h0, bus.stage_tap[23:16]}, 32'h66);
    chk("lat3_valid", {31'h0, bus.out_valid}, 32'h1);
    wait_drain();

    // Back-pressure: 8 words with a 4-cycle output hold mid-stream
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] w;
          w = 8'(i * 8'h13 + 1);
          send(w, {8'h44, 8'h22, 8'h11}, 1'b0, w ^ 8'h77);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
          chk("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", {28'h0, bus.out_count}, 32'h8);

    // Accumulate mode
    do_reset();
    send(8'h01, 24'h0, 1'b0, 8'h01);
    send(8'h02, 24'h0, 1'b1, 8'h03);
    send(8'h04, 24'h0, 1'b1, 8'h07);
    wait_drain();
    chk("acc_value_07", {24'h0, bus.acc_value}, 32'h07);
    send(8'h10, 24'h0, 1'b0, 8'h10);
    wait_drain();
    chk("acc_value_10", {24'h0, bus.acc_value}, 32'h10);

    // Async reset with two words in flight
    send(8'h5A, 24'h0, 1'b1, 8'h4A);
    send(8'h3C, 24'h0, 1'b0, 8'h3C);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_out_data",  {24'h0, bus.out_data}, 32'h0);
    chk("arst_acc_value", {24'h0, bus.acc_value}, 32'h0);
    chk("arst_out_count", {28'h0, bus.out_count}, 32'h0);
    chk("arst_stage_tap", {8'h0, bus.stage_tap}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'h0, bus.out_valid}, 32'h0);
    end

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++)
      send(8'(i), 24'h0, 1'b0, 8'(i));
    wait_drain();
    chk("count_wrap", {28'h0, bus.out_count}, 32'h1);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
